// File: rtl/irq_pkg.sv
// ---------------------------------------------------------------------------
// irq_pkg: shared types and constants for the interrupt controller. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package irq_pkg;

  localparam int DEF_N_IRQ = 8;

  typedef enum logic [1:0] {
    USER    = 2'd0,
    KERNEL  = 2'd1,
    HOLDOFF = 2'd2
  } irq_state_e;

  // The exception flag sits just above the channel-id field of cause.
  function automatic int cause_exc(input int id_w);
    return id_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/irq_ctrl_if.sv
// ---------------------------------------------------------------------------
// irq_ctrl_if: MMIO and ID-stage decoder signals of the interrupt controller. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface irq_ctrl_if
  import irq_pkg::*;
#(
  parameter int N_IRQ = DEF_N_IRQ,
  parameter int ID_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
);

  logic             mask_we;
  logic [N_IRQ-1:0] mask_wdata;
  logic             ack_we;
  logic [N_IRQ-1:0] ack_wdata;
  logic             enter_irq;
  logic             enter_exc;
  logic             exit_kernel;
  logic             irq_req;
  logic             supervised;
  logic [ID_W:0]    cause;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] mask;

  modport master (
    output mask_we, mask_wdata, ack_we, ack_wdata,
           enter_irq, enter_exc, exit_kernel,
    input  irq_req, supervised, cause, pending, mask
  );

  modport slave (
    input  mask_we, mask_wdata, ack_we, ack_wdata,
           enter_irq, enter_exc, exit_kernel,
    output irq_req, supervised, cause, pending, mask
  );

endinterface

`default_nettype wire

// File: rtl/irq_sync_edge.sv
// ---------------------------------------------------------------------------
// irq_sync_edge: per-channel 2-FF synchroniser, edge detect and pending bit. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module irq_sync_edge #(
  parameter bit EDGE = 1'b1
) (
  input  wire  clk,
  input  wire  reset_n,
  input  wire  irq_in,
  input  wire  ack,
  output logic pending
);

  logic s1;
  logic s2;
  logic s2_d;
  logic rise;
  logic pend_next;

  assign rise = s2 & ~s2_d;

  // Edge mode: a fresh edge beats a same-cycle ack. Level mode ignores ack.
  assign pend_next = EDGE ? (rise | (pending & ~ack)) : s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s2_d    <= 1'b0;
      pending <= 1'b0;
    end else begin
      s1      <= irq_in;
      s2      <= s1;
      s2_d    <= s2;
      pending <= pend_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/irq_ctrl.sv
// ---------------------------------------------------------------------------
// irq_ctrl: N-channel maskable prioritised interrupt controller with supervisor FSM. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module irq_ctrl
  import irq_pkg::*;
#(
  parameter int               N_IRQ     = DEF_N_IRQ,
  parameter logic [N_IRQ-1:0] EDGE_MASK = '1,
  parameter int               ID_W      = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  wire             clk,
  input  wire             reset_n,
  input  wire [N_IRQ-1:0] irq_in,
  irq_ctrl_if.slave       bus
);

  localparam int CAUSE_EXC = cause_exc(ID_W);

  irq_state_e       state;
  irq_state_e       next_state;
  logic [ID_W:0]    cause_q;
  logic [ID_W:0]    cause_next;
  logic [N_IRQ-1:0] mask_q;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] active;
  logic [ID_W-1:0]  irq_id;
  logic             irq_req;

  genvar gi;
  generate
    for (gi = 0; gi < N_IRQ; gi++) begin : g_chan
      irq_sync_edge #(
        .EDGE (EDGE_MASK[gi])
      ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .irq_in  (irq_in[gi]),
        .ack     (bus.ack_we & bus.ack_wdata[gi]),
        .pending (pending[gi])
      );
    end
  endgenerate

  assign active  = pending & mask_q;
  assign irq_req = (|active) && (state == USER);

  // Scan downwards so the lowest set index (highest priority) is written last.
  always_comb begin
    irq_id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (active[i]) irq_id = ID_W'(i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= USER;
      cause_q <= '0;
      mask_q  <= '0;
    end else begin
      state   <= next_state;
      cause_q <= cause_next;
      if (bus.mask_we) mask_q <= bus.mask_wdata;
    end
  end

  always_comb begin
    next_state = state;
    cause_next = cause_q;
    case (state)
      USER: begin
        if (bus.enter_irq && irq_req) begin
          next_state = KERNEL;
          cause_next = {1'b0, irq_id};
        end else if (bus.enter_exc) begin
          next_state            = KERNEL;
          cause_next            = '0;
          cause_next[CAUSE_EXC] = 1'b1;
        end
      end
      KERNEL: begin
        if (bus.exit_kernel) next_state = HOLDOFF;
      end
      // One forced user cycle so at least one user instruction issues between visits.
      HOLDOFF: next_state = USER;
      default: next_state = USER;
    endcase
  end

  assign bus.irq_req    = irq_req;
  assign bus.supervised = (state == KERNEL);
  assign bus.cause      = cause_q;
  assign bus.pending    = pending;
  assign bus.mask       = mask_q;

endmodule

`default_nettype wire
